// File: rtl/jedro_1_prefetch.sv
// Instruction prefetch buffer: streams sequential word fetches into a small FIFO
// and flushes/redirects on jmp_i. Memory answers exactly one cycle after a request.
module jedro_1_prefetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  jmp_i,
    input  logic [DATA_WIDTH-1:0] jmp_addr_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] addr_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  mem_req_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] fetch_pc;
    logic [DATA_WIDTH-1:0] issued_addr;
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] addr_mem  [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         level;
    logic                  inflight;
    logic                  discard;
    logic                  push;
    logic                  pop;

    // Reserve a slot for the outstanding response; a same-cycle pop earns no credit.
    assign level      = count + CW'(inflight);
    assign mem_req_o  = !rst_i && !jmp_i && (level < DEPTH_C);
    assign mem_addr_o = fetch_pc;

    assign valid_o = (count != '0);
    assign instr_o = instr_mem[rd_ptr];
    assign addr_o  = addr_mem[rd_ptr];

    assign pop  = valid_o && ready_i;
    assign push = inflight && !discard && !jmp_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= BOOT_ADDR;
            issued_addr <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            inflight    <= 1'b0;
            discard     <= 1'b0;
        end else begin
            inflight <= mem_req_o;
            if (mem_req_o) begin
                issued_addr <= fetch_pc;
            end
            if (jmp_i) begin
                fetch_pc <= jmp_addr_i & ~DATA_WIDTH'(3);
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                discard  <= inflight;
            end else begin
                discard <= 1'b0;
                if (mem_req_o) begin
                    fetch_pc <= fetch_pc + DATA_WIDTH'(4);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: storage is not reset; count gates validity, so stale contents are never seen.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            instr_mem[wr_ptr] <= mem_rdata_i;
            addr_mem[wr_ptr]  <= issued_addr;
        end
    end

endmodule

// File: tb/tb_jedro_1_prefetch.sv
// Directed bench for jedro_1_prefetch: the memory model answers addr ^ 32'hAAAA_0000
// one cycle after each request. Inputs change after the falling edge and outputs are checked 1 ns later.
module tb_jedro_1_prefetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        jmp_i;
    logic [31:0] jmp_addr_i;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        valid_o;
    logic        ready_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_rdata_i;

    int          errors = 0;
    int          checks = 0;
    int          xfers  = 0;
    int          x0;
    logic [31:0] last_req_addr;
    logic [31:0] last_xfer_addr = '0;

    jedro_1_prefetch #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .BOOT_ADDR  (32'h0000_0000)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .jmp_i       (jmp_i),
        .jmp_addr_i  (jmp_addr_i),
        .instr_o     (instr_o),
        .addr_o      (addr_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory returns data for the previous cycle's address; the consumer logs accepted heads.
    always @(posedge clk_i) begin
        last_req_addr <= mem_addr_o;
        if (!rst_i && valid_o && ready_i) begin
            xfers          <= xfers + 1;
            last_xfer_addr <= addr_o;
        end
    end
    assign mem_rdata_i = last_req_addr ^ 32'hAAAA_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic j, input logic rdy, input logic [31:0] ja);
        @(negedge clk_i);
        rst_i      = r;
        jmp_i      = j;
        ready_i    = rdy;
        jmp_addr_i = ja;
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        step(1'b1, 1'b0, rdy, 32'h0);
        step(1'b1, 1'b0, rdy, 32'h0);
    endtask

    initial begin
        rst_i      = 1'b1;
        jmp_i      = 1'b0;
        ready_i    = 1'b1;
        jmp_addr_i = '0;

        // Streaming with ready held high: one request and one delivery per cycle.
        do_reset(1'b1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("a0_req", 32'(mem_req_o), 32'd1);
        check("a0_addr", mem_addr_o, 32'h0);
        check("a0_valid", 32'(valid_o), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            check("stream_req", 32'(mem_req_o), 32'd1);
            check("stream_mem_addr", mem_addr_o, 32'(4 * k));
            if (k == 1) begin
                check("a1_valid", 32'(valid_o), 32'd0);
            end else begin
                check("stream_valid", 32'(valid_o), 32'd1);
                check("stream_addr", addr_o, 32'(4 * (k - 2)));
                check("stream_instr", instr_o, 32'(4 * (k - 2)) ^ 32'hAAAA_0000);
            end
        end

        // Consumer stalled from reset: exactly four requests, then the head is held.
        do_reset(1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("b0_addr", mem_addr_o, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            check("fill_req", 32'(mem_req_o), 32'd1);
            check("fill_addr", mem_addr_o, 32'(4 * k));
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            check("full_req", 32'(mem_req_o), 32'd0);
            check("full_valid", 32'(valid_o), 32'd1);
            check("hold_addr", addr_o, 32'h0);
            check("hold_instr", instr_o, 32'hAAAA_0000);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("no_pop_credit", 32'(mem_req_o), 32'd0);
        check("resume_pc", mem_addr_o, 32'h10);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("resume_req", 32'(mem_req_o), 32'd1);
        check("resume_addr", mem_addr_o, 32'h10);
        check("resume_head", addr_o, 32'h4);

        // Full buffer redirected to an unaligned target while the head is accepted.
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        check("pre_jmp_head", addr_o, 32'h0);
        x0 = xfers;
        step(1'b0, 1'b1, 1'b1, 32'h103);
        check("jmp_req", 32'(mem_req_o), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("flush_valid", 32'(valid_o), 32'd0);
        check("redir_req", 32'(mem_req_o), 32'd1);
        check("redir_addr", mem_addr_o, 32'h100);
        check("jmp_xfer_once", 32'(xfers - x0), 32'd1);
        check("jmp_xfer_addr", last_xfer_addr, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("redir_valid1", 32'(valid_o), 32'd0);
        check("redir_addr2", mem_addr_o, 32'h104);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("redir_head_valid", 32'(valid_o), 32'd1);
        check("redir_head_addr", addr_o, 32'h100);
        check("redir_head_instr", instr_o, 32'hAAAA_0100);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("redir_next_addr", addr_o, 32'h104);

        // Redirect while the response for 0x8 is in flight: that response is dropped.
        do_reset(1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("d2_req_addr", mem_addr_o, 32'h8);
        step(1'b0, 1'b1, 1'b1, 32'h200);
        check("d3_valid", 32'(valid_o), 32'd1);
        check("d3_head", addr_o, 32'h4);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("d4_last_xfer", last_xfer_addr, 32'h4);
        check("d4_valid", 32'(valid_o), 32'd0);
        check("d4_addr", mem_addr_o, 32'h200);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("d5_valid", 32'(valid_o), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("d6_head", addr_o, 32'h200);
        check("d6_instr", instr_o, 32'hAAAA_0200);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("d7_head", addr_o, 32'h204);

        // Back-to-back redirects: the last target wins.
        step(1'b0, 1'b1, 1'b1, 32'h400);
        check("jj1_req", 32'(mem_req_o), 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h504);
        check("jj2_req", 32'(mem_req_o), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("jj_req", 32'(mem_req_o), 32'd1);
        check("jj_addr", mem_addr_o, 32'h504);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("jj_valid", 32'(valid_o), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("jj_head", addr_o, 32'h504);

        // Reset mid-stream with three entries buffered and one response outstanding.
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("e4_req", 32'(mem_req_o), 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'h300);
        check("e5_valid", 32'(valid_o), 32'd0);
        check("e5_req", 32'(mem_req_o), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("e6_req", 32'(mem_req_o), 32'd1);
        check("e6_boot", mem_addr_o, 32'h0);
        check("e6_valid", 32'(valid_o), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("e7_valid", 32'(valid_o), 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check("e8_valid", 32'(valid_o), 32'd1);
        check("e8_head", addr_o, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
